mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter AW, default 32: data-memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles in WAIT before a bus error; range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port mem_valid_i, input, 1: MEM-stage instruction is a load or store.
REQ-006 SHALL have port mem_we_i, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port funct3_i, input, 3: RV32 width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port addr_i, input, AW: byte address.
REQ-009 SHALL have port rd2_data_i, input, 32: store data from EX/MEM.
REQ-010 SHALL have port fwd_data_i, input, 32: forwarded WB-stage data.
REQ-011 SHALL have port fwd_sel_i, input, 1: use fwd_data_i as store data.
REQ-012 SHALL have port stall_o, output, 1: freeze upstream pipeline.
REQ-013 SHALL have port dmem_req_o, output, 1: memory request.
REQ-014 SHALL have port dmem_we_o, output, 1: request is a write.
REQ-015 SHALL have port dmem_addr_o, output, AW: word-aligned address, low two bits 0.
REQ-016 SHALL have port dmem_be_o, output, 4: byte enables.
REQ-017 SHALL have port dmem_wdata_o, output, 32: lane-shifted write data.
REQ-018 SHALL have port dmem_gnt_i, input, 1: request accepted.
REQ-019 SHALL have port dmem_rvalid_i, input, 1: response valid (reads and writes).
REQ-020 SHALL have port dmem_rdata_i, input, 32: read data.
REQ-021 SHALL have port load_data_o, output, 32: aligned, extended load result.
REQ-022 SHALL have port done_o, output, 1: one-cycle pulse, access complete.
REQ-023 SHALL have port misalign_o, output, 1: one-cycle pulse, misaligned access, no request issued.
REQ-024 SHALL have port bus_err_o, output, 1: one-cycle pulse, TIMEOUT expired.

Function
REQ-025 SHALL run an FSM with states IDLE, REQ, WAIT.
REQ-026 IDLE, mem_valid_i=1, aligned access: SHALL register the request and go to REQ next cycle; stall_o=1 from that cycle.
REQ-027 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. SHALL pulse misalign_o, stay in IDLE, keep stall_o=0, issue no request.
REQ-028 Store data SHALL be fwd_data_i when fwd_sel_i=1, else rd2_data_i, sampled when the request is registered.
REQ-029 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. Write data replicated to all lanes; loads drive be=4'b1111.
REQ-030 REQ: dmem_req_o=1 and address, be, we and wdata stable until dmem_gnt_i=1, then go to WAIT with dmem_req_o=0.
REQ-031 WAIT: on dmem_rvalid_i, SHALL pulse done_o, go to IDLE, drop stall_o the same cycle. Load data is lane-selected by addr[1:0]; sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-032 gnt and rvalid in the same cycle SHALL count as gnt only; rvalid is honoured from the WAIT cycle onward.
REQ-033 SHALL count WAIT cycles from 0; when the count reaches TIMEOUT without rvalid, SHALL pulse bus_err_o, go to IDLE, drop stall_o. No timeout applies in REQ.
REQ-034 load_data_o SHALL hold its last value until the next completed load.
REQ-035 mem_valid_i SHALL be ignored outside IDLE; a new request is accepted in the cycle after done_o.

Reset
REQ-036 rst_n low SHALL force, asynchronously, state IDLE, counter 0, and all outputs 0 (load_data_o=0), including mid-transaction; a stale rvalid after reset is ignored.
REQ-037 Reset release SHALL be synchronised by the caller; the block accepts a request on the first clock edge after release.

Structure
REQ-038 funct3 codes, the FSM state enum and lane helpers SHALL live in the shared package riscv_pkg.
REQ-039 Load alignment/extension SHALL be a combinational sub-module lsu_load_align.

Verification
REQ-040 SB: addr 0x1003, rd2=0x000000AB, gnt same cycle -> be=4'b1000, wdata=0xABABABAB, addr 0x1000, done_o 1 cycle after rvalid.
REQ-041 LH: addr 0x2002, rdata=0x8001xxxx -> load_data_o=0xFFFF8001; LHU -> 0x00008001.
REQ-042 SW: addr 0x3001 -> misalign_o pulse, dmem_req_o stays 0, stall_o stays 0.
REQ-043 Load: gnt delayed 3 cycles, no rvalid for 15 WAIT cycles -> bus_err_o pulse, stall_o released.
REQ-044 SW: fwd_sel_i=1, fwd=0xDEADBEEF, rd2=0x0 -> wdata=0xDEADBEEF; rst_n low in WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 codes, LSU FSM states and lane helpers
// used by the data-memory load/store unit.
package riscv_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access size lives in funct3[1:0]; anything other than byte/half is a word.
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic [3:0]  be;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [1:0] off);
      logic m;
      m = 1'b0;
      if (sz == SZ_H && off[0])
         m = 1'b1;
      else if (sz[1] && off != 2'b00)
         m = 1'b1;
      return m;
   endfunction

   function automatic logic [3:0] lsu_be(input logic we, input logic [1:0] sz,
                                         input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      if (we) begin
         case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

   function automatic logic [31:0] lsu_wdata(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] w;
      case (sz)
         SZ_B:    w = {4{d[7:0]}};
         SZ_H:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data lane select and sign/zero extension.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;
   logic        sext;

   assign shifted = rdata_i >> {off_i, 3'b000};
   // funct3[2] marks the unsigned variants (LBU/LHU).
   assign sext    = ~funct3_i[2];

   always_comb begin
      data_o = shifted;
      case (funct3_i[1:0])
         SZ_B:    data_o = {{24{shifted[7] & sext}}, shifted[7:0]};
         SZ_H:    data_o = {{16{shifted[15] & sext}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: registers one access, runs a req/gnt/rvalid handshake
// with data memory, aligns load data and times out a silent bus.
module mem_lsu
   import riscv_pkg::*;
#(
   parameter int AW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem_valid_i,
   input  logic          mem_we_i,
   input  logic [2:0]    funct3_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   rd2_data_i,
   input  logic [31:0]   fwd_data_i,
   input  logic          fwd_sel_i,
   output logic          stall_o,
   output logic          dmem_req_o,
   output logic          dmem_we_o,
   output logic [AW-1:0] dmem_addr_o,
   output logic [3:0]    dmem_be_o,
   output logic [31:0]   dmem_wdata_o,
   input  logic          dmem_gnt_i,
   input  logic          dmem_rvalid_i,
   input  logic [31:0]   dmem_rdata_i,
   output logic [31:0]   load_data_o,
   output logic          done_o,
   output logic          misalign_o,
   output logic          bus_err_o
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   lsu_state_e      state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   lsu_req_t        req_q, req_d;
   logic [AW-1:2]   waddr_q, waddr_d;
   logic [31:0]     load_q, load_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            mis_q, mis_d;
   logic            accept;
   logic            idle_rdy;
   logic            misal;
   logic [31:0]     st_data;
   logic [31:0]     ld_aligned;

   lsu_load_align u_align (
      .funct3_i (req_q.funct3),
      .off_i    (req_q.off),
      .rdata_i  (dmem_rdata_i),
      .data_o   (ld_aligned)
   );

   // The just-finished instruction is still in MEM during its done/err cycle.
   assign idle_rdy = ~done_q & ~err_q;
   assign misal    = lsu_misaligned(funct3_i[1:0], addr_i[1:0]);
   assign st_data  = fwd_sel_i ? fwd_data_i : rd2_data_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      waddr_d = waddr_q;
      load_d  = load_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_valid_i && idle_rdy) begin
               if (misal) begin
                  mis_d = 1'b1;
               end else begin
                  accept       = 1'b1;
                  req_d.we     = mem_we_i;
                  req_d.funct3 = funct3_i;
                  req_d.off    = addr_i[1:0];
                  req_d.be     = lsu_be(mem_we_i, funct3_i[1:0], addr_i[1:0]);
                  req_d.wdata  = lsu_wdata(funct3_i[1:0], st_data);
                  waddr_d      = addr_i[AW-1:2];
                  state_d      = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // An rvalid coincident with gnt belongs to nobody; only WAIT honours it.
            if (dmem_gnt_i) begin
               cnt_d   = 8'd0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_i) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
               if (!req_q.we)
                  load_d = ld_aligned;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         waddr_q <= '0;
         load_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         waddr_q <= waddr_d;
         load_q  <= load_d;
         done_q  <= done_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   // Stall already in the accepting cycle so the instruction stays in MEM.
   assign stall_o      = (state_q != ST_IDLE) | accept;
   assign dmem_req_o   = (state_q == ST_REQ);
   assign dmem_we_o    = req_q.we;
   assign dmem_addr_o  = {waddr_q, 2'b00};
   assign dmem_be_o    = req_q.be;
   assign dmem_wdata_o = req_q.wdata;
   assign load_data_o  = load_q;
   assign done_o       = done_q;
   assign misalign_o   = mis_q;
   assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table of single accesses plus timeout and reset sequences.
module tb_mem_lsu;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_valid_i = 1'b0, mem_we_i = 1'b0, fwd_sel_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] addr_i = '0, rd2_data_i = '0, fwd_data_i = '0;
   logic        stall_o, dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, load_data_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;
   logic        done_o, misalign_o, bus_err_o;

   int          nchk = 0;
   int          nerr = 0;
   logic [31:0] last_load = '0;

   mem_lsu #(.AW(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .funct3_i(funct3_i),
      .addr_i(addr_i), .rd2_data_i(rd2_data_i), .fwd_data_i(fwd_data_i),
      .fwd_sel_i(fwd_sel_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .load_data_o(load_data_o), .done_o(done_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] rd2;
      logic [31:0] fwd;
      logic        fsel;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_load;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] rd2,
                               logic [31:0] fwd, logic fsel, logic [31:0] rdata, logic mis,
                               logic [3:0] be, logic [31:0] wd, logic [31:0] ld);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.rd2 = rd2; v.fwd = fwd; v.fsel = fsel;
      v.rdata = rdata; v.mis = mis; v.e_be = be; v.e_wdata = wd; v.e_load = ld;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd2, input logic [31:0] fwd, input logic fs);
      mem_valid_i = 1'b1; mem_we_i = we; funct3_i = f3; addr_i = a;
      rd2_data_i = rd2; fwd_data_i = fwd; fwd_sel_i = fs;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      drive_req(v.we, v.f3, v.addr, v.rd2, v.fwd, v.fsel);
      #1;
      chk($sformatf("v%0d_stall_accept", i), stall_o, !v.mis);
      cyc();
      mem_valid_i = 1'b0;
      if (v.mis) begin
         chk($sformatf("v%0d_misalign", i), misalign_o, 1'b1);
         chk($sformatf("v%0d_mis_noreq", i), dmem_req_o, 1'b0);
         chk($sformatf("v%0d_mis_stall", i), stall_o, 1'b0);
         cyc();
         chk($sformatf("v%0d_mis_pulse_end", i), misalign_o, 1'b0);
         chk($sformatf("v%0d_mis_noreq2", i), dmem_req_o, 1'b0);
         chk($sformatf("v%0d_mis_load_hold", i), load_data_o, last_load);
         return;
      end
      chk($sformatf("v%0d_req", i), dmem_req_o, 1'b1);
      chk($sformatf("v%0d_stall_req", i), stall_o, 1'b1);
      chk($sformatf("v%0d_we", i), dmem_we_o, v.we);
      chk($sformatf("v%0d_addr", i), dmem_addr_o, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_be", i), dmem_be_o, v.e_be);
      if (v.we) chk($sformatf("v%0d_wdata", i), dmem_wdata_o, v.e_wdata);
      // rvalid alongside gnt must not complete the access
      dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5A5A_5A5A;
      cyc();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      chk($sformatf("v%0d_wait_noreq", i), dmem_req_o, 1'b0);
      chk($sformatf("v%0d_wait_stall", i), stall_o, 1'b1);
      chk($sformatf("v%0d_wait_nodone", i), done_o, 1'b0);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata;
      cyc();
      dmem_rvalid_i = 1'b0;
      chk($sformatf("v%0d_done", i), done_o, 1'b1);
      chk($sformatf("v%0d_done_stall", i), stall_o, 1'b0);
      if (!v.we) last_load = v.e_load;
      chk($sformatf("v%0d_load", i), load_data_o, last_load);
      cyc();
      chk($sformatf("v%0d_done_end", i), done_o, 1'b0);
   endtask

   initial begin
      vecs.push_back(mk(1, F3_SB,  32'h1003, 32'h0000_00AB, 32'h1111_1111, 0, 0, 0, 4'b1000, 32'hABAB_ABAB, 0));
      vecs.push_back(mk(0, F3_LH,  32'h2002, 0, 0, 0, 32'h8001_1234, 0, 4'b1111, 0, 32'hFFFF_8001));
      vecs.push_back(mk(0, F3_LHU, 32'h2002, 0, 0, 0, 32'h8001_1234, 0, 4'b1111, 0, 32'h0000_8001));
      vecs.push_back(mk(1, F3_SW,  32'h3001, 32'h1234_5678, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, F3_SW,  32'h3000, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk(0, F3_LB,  32'h4001, 0, 0, 0, 32'h1234_9A78, 0, 4'b1111, 0, 32'hFFFF_FF9A));
      vecs.push_back(mk(0, F3_LBU, 32'h4001, 0, 0, 0, 32'h1234_9A78, 0, 4'b1111, 0, 32'h0000_009A));
      vecs.push_back(mk(1, F3_SH,  32'h5002, 32'h1234_ABCD, 0, 0, 0, 0, 4'b1100, 32'hABCD_ABCD, 0));
      vecs.push_back(mk(0, F3_LH,  32'h6001, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, F3_SB,  32'h7000, 32'h0000_00FF, 32'h0000_0055, 1, 0, 0, 4'b0001, 32'h5555_5555, 0));
      vecs.push_back(mk(0, F3_LB,  32'h4003, 0, 0, 0, 32'h7F00_0000, 0, 4'b1111, 0, 32'h0000_007F));
      vecs.push_back(mk(0, F3_LW,  32'h4002, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, F3_SH,  32'h5001, 32'h1111_2222, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, F3_LHU, 32'h4000, 0, 0, 0, 32'h1234_FFEE, 0, 4'b1111, 0, 32'h0000_FFEE));
      vecs.push_back(mk(0, F3_LW,  32'h4004, 0, 0, 0, 32'hCAFE_F00D, 0, 4'b1111, 0, 32'hCAFE_F00D));

      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_stall", stall_o, 0);
      chk("rst_req", dmem_req_o, 0);
      chk("rst_addr", dmem_addr_o, 0);
      chk("rst_be", dmem_be_o, 0);
      chk("rst_load", load_data_o, 0);
      chk("rst_pulses", {done_o, misalign_o, bus_err_o}, 0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // load with gnt held off 3 cycles, then silent bus until timeout
      drive_req(0, F3_LW, 32'h8000, 0, 0, 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("to_req_hold%0d", k), dmem_req_o, 1'b1);
         chk($sformatf("to_addr_hold%0d", k), dmem_addr_o, 32'h8000);
         chk($sformatf("to_stall_req%0d", k), stall_o, 1'b1);
         cyc();
      end
      chk("to_req_before_gnt", dmem_req_o, 1'b1);
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         chk($sformatf("to_wait%0d_stall", k), stall_o, 1'b1);
         chk($sformatf("to_wait%0d_noerr", k), bus_err_o, 1'b0);
         chk($sformatf("to_wait%0d_noreq", k), dmem_req_o, 1'b0);
         cyc();
      end
      chk("to_bus_err", bus_err_o, 1'b1);
      chk("to_stall_released", stall_o, 1'b0);
      chk("to_no_done", done_o, 1'b0);
      chk("to_load_hold", load_data_o, last_load);
      mem_valid_i = 1'b0;
      cyc();
      chk("to_bus_err_end", bus_err_o, 1'b0);
      chk("to_idle_noreq", dmem_req_o, 1'b0);

      // forwarded store data, then reset while waiting for the response
      drive_req(1, F3_SW, 32'h9000, 32'h0, 32'hDEAD_BEEF, 1);
      cyc();
      chk("rw_wdata_fwd", dmem_wdata_o, 32'hDEAD_BEEF);
      chk("rw_req", dmem_req_o, 1'b1);
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      mem_valid_i = 1'b0;
      chk("rw_wait_stall", stall_o, 1'b1);
      #2 rst_n = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
      #1;
      chk("rw_rst_stall", stall_o, 0);
      chk("rw_rst_req", dmem_req_o, 0);
      chk("rw_rst_we", dmem_we_o, 0);
      chk("rw_rst_addr", dmem_addr_o, 0);
      chk("rw_rst_be", dmem_be_o, 0);
      chk("rw_rst_wdata", dmem_wdata_o, 0);
      chk("rw_rst_load", load_data_o, 0);
      chk("rw_rst_pulses", {done_o, misalign_o, bus_err_o}, 0);
      cyc();
      rst_n = 1'b1;
      last_load = '0;
      // stale rvalid still high; request accepted on first edge after release
      drive_req(0, F3_LW, 32'h4004, 0, 0, 0);
      #1;
      chk("rw_first_accept_stall", stall_o, 1'b1);
      cyc();
      chk("rw_stale_nodone", done_o, 1'b0);
      chk("rw_first_req", dmem_req_o, 1'b1);
      chk("rw_first_addr", dmem_addr_o, 32'h4004);
      dmem_rvalid_i = 1'b0;
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
      cyc();
      dmem_rvalid_i = 1'b0;
      chk("rw_done", done_o, 1'b1);
      chk("rw_done_stall_low", stall_o, 1'b0);
      chk("rw_load", load_data_o, 32'hCAFE_F00D);
      cyc();
      // mem_valid held through done: accepted only in the following cycle
      chk("rw_next_accept_stall", stall_o, 1'b1);
      chk("rw_next_done_end", done_o, 1'b0);
      cyc();
      mem_valid_i = 1'b0;
      chk("rw_next_req", dmem_req_o, 1'b1);
      dmem_gnt_i = 1'b1;
      cyc();
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_F00D;
      cyc();
      dmem_rvalid_i = 1'b0;
      chk("rw_next_done", done_o, 1'b1);
      chk("rw_next_load", load_data_o, 32'h0BAD_F00D);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
